// File: rtl/meas_pkg.sv
// Shared measurement types: threshold and delay code widths, sweep FSM states.
// No logic; consumed by ch_sweep_ctl, cmp_vote and the measure unit.
// Width constants here are the single source for all per-channel blocks.
package meas_pkg;

   localparam int THR_W   = 16;
   localparam int DCODE_W = 10;
   localparam int VCNT_W  = 4;   // vote counters, enough for up to 15 votes

   typedef logic [THR_W-1:0]   thr_code_t;
   typedef logic [DCODE_W-1:0] d_code_t;

   localparam thr_code_t THR_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_DAC,
      DAC_WAIT,
      VOTE,
      EVAL,
      EMIT
   } sweep_state_e;

   // A zero step would stall the search, so it is promoted to one.
   function automatic thr_code_t thr_step_nz(input thr_code_t d);
      return (d == '0) ? thr_code_t'(1) : d;
   endfunction

   function automatic d_code_t d_step_nz(input d_code_t d);
      return (d == '0) ? d_code_t'(1) : d;
   endfunction

endpackage

// File: rtl/cmp_vote.sv
// Comparator majority voter: synchronises cmp, samples SAMPLE_DLY cycles after each strobe.
// Latency: res_vld one cycle after the VOTES-th sample edge.
// No backpressure; dropping start discards any partial vote and open window.
module cmp_vote
   import meas_pkg::*;
#(
   parameter int SAMPLE_DLY = 4,
   parameter int VOTES      = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start,
   input  logic stb_i,
   input  logic cmp_out_i,
   output logic res_vld,
   output logic res
);

   localparam int WIN_W = (SAMPLE_DLY < 2) ? 1 : $clog2(SAMPLE_DLY + 1);

   logic              cmp_s1;
   logic              cmp_s2;
   logic              win_open;
   logic [WIN_W-1:0]  win_cnt;
   logic [VCNT_W-1:0] vote_cnt;
   logic [VCNT_W-1:0] ones;
   logic [VCNT_W-1:0] ones_n;

   assign ones_n = ones + VCNT_W'(cmp_s2);

   // Two-flop synchroniser for the asynchronous comparator output.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cmp_s1 <= 1'b0;
         cmp_s2 <= 1'b0;
      end else begin
         cmp_s1 <= cmp_out_i;
         cmp_s2 <= cmp_s1;
      end
   end

   // Sample window per strobe (strobes inside an open window are ignored) and vote tally.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || !start) begin
         win_open <= 1'b0;
         win_cnt  <= '0;
         vote_cnt <= '0;
         ones     <= '0;
         res_vld  <= 1'b0;
         res      <= 1'b0;
      end else begin
         res_vld <= 1'b0;
         if (win_open) begin
            if (win_cnt == WIN_W'(SAMPLE_DLY)) begin
               win_open <= 1'b0;
               if (vote_cnt == VCNT_W'(VOTES - 1)) begin
                  res_vld  <= 1'b1;
                  res      <= (ones_n > VCNT_W'(VOTES / 2));
                  vote_cnt <= '0;
                  ones     <= '0;
               end else begin
                  vote_cnt <= vote_cnt + VCNT_W'(1);
                  ones     <= ones_n;
               end
            end else begin
               win_cnt <= win_cnt + WIN_W'(1);
            end
         end else if (stb_i && !res_vld) begin
            win_open <= 1'b1;
            win_cnt  <= WIN_W'(1);
         end
      end
   end

endmodule

// File: rtl/ch_sweep_ctl.sv
// Equivalent-time sweep: per delay code, step the threshold until cmp flips, emit the point.
// Latency: one point per delay code; each decision costs DAC load + VOTES strobe windows.
// No backpressure on points (one-cycle pulse); DAC writes wait for threshold_rdy_i.
module ch_sweep_ctl
   import meas_pkg::*;
#(
   parameter thr_code_t THR_INIT   = 16'h8000,
   parameter d_code_t   D_CODE_MAX = 10'h3FF,
   parameter int        SAMPLE_DLY = 4,
   parameter int        VOTES      = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               run_i,
   input  logic               abort_i,
   input  logic               stb_i,
   input  logic               cmp_out_i,
   input  logic [THR_W-1:0]   threshold_delta_i,
   input  logic [DCODE_W-1:0] d_code_delta_i,
   output logic [THR_W-1:0]   threshold_o,
   output logic               threshold_wre_o,
   input  logic               threshold_rdy_i,
   output logic [DCODE_W-1:0] d_code_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               point_rdy_o,
   output logic [THR_W-1:0]   point_v_o,
   output logic [DCODE_W-1:0] point_t_o,
   output logic               point_sat_o
);

   sweep_state_e     state_q, state_d;
   thr_code_t        thr_q, thr_d, thr_step_q, thr_step_d;
   d_code_t          dcode_q, dcode_d, d_step_q, d_step_d;
   logic             first_q, first_d, ref_q, ref_d, dir_q, dir_d;
   logic             res_q, res_d, sat_q, sat_d, skip_q, skip_d, done_q, done_d;
   logic             wre, emit, vote_en, step_dir;
   logic             vote_vld, vote_res;
   logic [THR_W:0]   thr_up;
   logic [DCODE_W:0] d_next;

   cmp_vote #(
      .SAMPLE_DLY (SAMPLE_DLY),
      .VOTES      (VOTES)
   ) u_vote (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start     (vote_en),
      .stb_i     (stb_i),
      .cmp_out_i (cmp_out_i),
      .res_vld   (vote_vld),
      .res       (vote_res)
   );

   // Next-state, threshold search and point emission; abort overrides everything.
   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      dcode_d    = dcode_q;
      thr_step_d = thr_step_q;
      d_step_d   = d_step_q;
      first_d    = first_q;
      ref_d      = ref_q;
      dir_d      = dir_q;
      res_d      = res_q;
      sat_d      = sat_q;
      skip_d     = skip_q;
      done_d     = 1'b0;
      wre        = 1'b0;
      emit       = 1'b0;
      vote_en    = 1'b0;
      // On the first decision of a delay code the direction comes from the fresh result.
      step_dir   = first_q ? res_q : dir_q;
      thr_up     = {1'b0, thr_q} + {1'b0, thr_step_q};
      d_next     = {1'b0, dcode_q} + {1'b0, d_step_q};
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (run_i) begin
                  state_d    = LOAD_DAC;
                  thr_d      = THR_INIT;
                  dcode_d    = '0;
                  first_d    = 1'b1;
                  sat_d      = 1'b0;
                  thr_step_d = thr_step_nz(threshold_delta_i);
                  d_step_d   = d_step_nz(d_code_delta_i);
               end
            end
            LOAD_DAC: begin
               if (threshold_rdy_i) begin
                  wre     = 1'b1;
                  skip_d  = 1'b1;
                  state_d = DAC_WAIT;
               end
            end
            DAC_WAIT: begin
               // rdy may still read idle the cycle after wre; skip that cycle.
               if (skip_q) begin
                  skip_d = 1'b0;
               end else if (threshold_rdy_i) begin
                  state_d = VOTE;
               end
            end
            VOTE: begin
               vote_en = 1'b1;
               if (vote_vld) begin
                  res_d   = vote_res;
                  state_d = EVAL;
               end
            end
            EVAL: begin
               if (!first_q && (res_q != ref_q)) begin
                  sat_d   = 1'b0;
                  state_d = EMIT;
               end else begin
                  if (first_q) begin
                     ref_d   = res_q;
                     dir_d   = res_q;
                     first_d = 1'b0;
                  end
                  state_d = LOAD_DAC;
                  if (step_dir) begin
                     if (thr_up[THR_W]) begin
                        if (thr_q == THR_MAX) begin
                           sat_d   = 1'b1;
                           state_d = EMIT;
                        end else begin
                           thr_d = THR_MAX;
                        end
                     end else begin
                        thr_d = thr_up[THR_W-1:0];
                     end
                  end else begin
                     if (thr_step_q > thr_q) begin
                        if (thr_q == '0) begin
                           sat_d   = 1'b1;
                           state_d = EMIT;
                        end else begin
                           thr_d = '0;
                        end
                     end else begin
                        thr_d = thr_q - thr_step_q;
                     end
                  end
               end
            end
            EMIT: begin
               emit  = 1'b1;
               sat_d = 1'b0;
               if (d_next > {1'b0, D_CODE_MAX}) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Threshold is kept so the next delay code starts near the edge.
                  dcode_d = d_next[DCODE_W-1:0];
                  first_d = 1'b1;
                  state_d = LOAD_DAC;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         thr_q      <= THR_INIT;
         dcode_q    <= '0;
         thr_step_q <= '0;
         d_step_q   <= '0;
         first_q    <= 1'b0;
         ref_q      <= 1'b0;
         dir_q      <= 1'b0;
         res_q      <= 1'b0;
         sat_q      <= 1'b0;
         skip_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         dcode_q    <= dcode_d;
         thr_step_q <= thr_step_d;
         d_step_q   <= d_step_d;
         first_q    <= first_d;
         ref_q      <= ref_d;
         dir_q      <= dir_d;
         res_q      <= res_d;
         sat_q      <= sat_d;
         skip_q     <= skip_d;
         done_q     <= done_d;
      end
   end

   assign threshold_o     = thr_q;
   assign threshold_wre_o = wre;
   assign d_code_o        = dcode_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = done_q;
   assign point_rdy_o     = emit;
   assign point_v_o       = emit ? thr_q : '0;
   assign point_t_o       = emit ? dcode_q : '0;
   assign point_sat_o     = emit & sat_q;

endmodule

// File: tb/tb_ch_sweep_ctl.sv
`timescale 1ns/1ps
module tb_ch_sweep_ctl;
   import meas_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_ni, run_i, abort_i, stb_i, cmp_out_i;
   logic [THR_W-1:0]   threshold_delta_i;
   logic [DCODE_W-1:0] d_code_delta_i;
   logic [THR_W-1:0]   threshold_o;
   logic               threshold_wre_o, threshold_rdy_i;
   logic [DCODE_W-1:0] d_code_o;
   logic               busy_o, done_o, point_rdy_o, point_sat_o;
   logic [THR_W-1:0]   point_v_o;
   logic [DCODE_W-1:0] point_t_o;

   int checks = 0;
   int errors = 0;

   // Comparator model: high while the threshold is below the signal level.
   logic        stb_auto_en = 1'b0, stb_auto = 1'b0, stb_man = 1'b0;
   logic        man_mode = 1'b0, cmp_man = 1'b0;
   logic [16:0] level = 17'h08010;
   assign stb_i     = stb_auto | stb_man;
   assign cmp_out_i = man_mode ? cmp_man : ({1'b0, threshold_o} < level);

   ch_sweep_ctl #(
      .THR_INIT   (16'h8000),
      .D_CODE_MAX (10'h3FF),
      .SAMPLE_DLY (4),
      .VOTES      (3)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .run_i             (run_i),
      .abort_i           (abort_i),
      .stb_i             (stb_i),
      .cmp_out_i         (cmp_out_i),
      .threshold_delta_i (threshold_delta_i),
      .d_code_delta_i    (d_code_delta_i),
      .threshold_o       (threshold_o),
      .threshold_wre_o   (threshold_wre_o),
      .threshold_rdy_i   (threshold_rdy_i),
      .d_code_o          (d_code_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .point_rdy_o       (point_rdy_o),
      .point_v_o         (point_v_o),
      .point_t_o         (point_t_o),
      .point_sat_o       (point_sat_o)
   );

   always #5 clk_i = ~clk_i;

   // Free-running strobe, one pulse every 8 cycles when enabled.
   initial forever begin
      repeat (7) @(posedge clk_i);
      #1 stb_auto = stb_auto_en;
      @(posedge clk_i);
      #1 stb_auto = 1'b0;
   end

   // Event monitor on the falling edge.
   int                 wre_cnt = 0, pt_cnt = 0, done_cnt = 0;
   logic [THR_W-1:0]   pv[$];
   logic [DCODE_W-1:0] pt[$];
   logic               ps[$];
   always @(negedge clk_i) begin
      if (threshold_wre_o) wre_cnt++;
      if (done_o) done_cnt++;
      if (point_rdy_o) begin
         pt_cnt++;
         pv.push_back(point_v_o);
         pt.push_back(point_t_o);
         ps.push_back(point_sat_o);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   function automatic int cnt_of(input int which);
      return (which == 0) ? wre_cnt : ((which == 1) ? pt_cnt : done_cnt);
   endfunction

   // which: 0 = wre, 1 = points, 2 = done. Timeout counts as a failed check.
   task automatic wait_cnt(input int which, input int n, input int budget, input string tag);
      int k = 0;
      while (cnt_of(which) < n && k < budget) begin
         cyc(1);
         k++;
      end
      chk(tag, 32'(cnt_of(which) >= n), 32'd1);
   endtask

   task automatic start_run(input logic [THR_W-1:0] td, input logic [DCODE_W-1:0] dd);
      threshold_delta_i = td;
      d_code_delta_i    = dd;
      run_i = 1'b1;
      cyc(1);
      run_i = 1'b0;
   endtask

   task automatic pulse_abort();
      abort_i = 1'b1;
      cyc(1);
      abort_i = 1'b0;
   endtask

   task automatic strobe(input logic v);
      cmp_man = v;
      cyc(1);
      stb_man = 1'b1;
      cyc(1);
      stb_man = 1'b0;
      cyc(8);
   endtask

   initial begin
      int b, w, d;
      rst_ni = 1'b0; run_i = 1'b0; abort_i = 1'b0;
      threshold_delta_i = '0; d_code_delta_i = '0; threshold_rdy_i = 1'b1;
      cyc(3);
      chk("rst_thr",   threshold_o, 32'h8000);
      chk("rst_dcode", d_code_o, 32'h0);
      chk("rst_busy",  busy_o, 32'h0);
      chk("rst_done",  done_o, 32'h0);
      chk("rst_wre",   threshold_wre_o, 32'h0);
      chk("rst_prdy",  point_rdy_o, 32'h0);
      chk("rst_pv",    point_v_o, 32'h0);
      chk("rst_pt",    point_t_o, 32'h0);
      chk("rst_psat",  point_sat_o, 32'h0);
      rst_ni = 1'b1;
      cyc(2);

      // Full sweep, static level 0x8010, step 8, delay step 0x100.
      stb_auto_en = 1'b1;
      level = 17'h08010;
      start_run(16'h0008, 10'h100);
      chk("run_busy", busy_o, 32'h1);
      wait_cnt(1, 1, 3000, "tmo_pt0");
      chk("pt0_v",   pv[0], 32'h8010);
      chk("pt0_t",   pt[0], 32'h0);
      chk("pt0_sat", ps[0], 32'h0);
      start_run(16'h0000, 10'h000);   // must be ignored while busy
      wait_cnt(1, 4, 6000, "tmo_pt4");
      wait_cnt(2, 1, 200, "tmo_done");
      chk("pt1_v", pv[1], 32'h8008);
      chk("pt1_t", pt[1], 32'h100);
      chk("pt2_v", pv[2], 32'h8010);
      chk("pt2_t", pt[2], 32'h200);
      chk("pt3_v", pv[3], 32'h8008);
      chk("pt3_t", pt[3], 32'h300);
      chk("done_busy", busy_o, 32'h0);
      cyc(60);
      chk("sweep_pts",  pt_cnt, 32'd4);
      chk("sweep_done", done_cnt, 32'd1);

      // Level above full scale: clamp to 0xFFFF then saturate.
      b = pt_cnt;
      level = 17'h10000;
      start_run(16'h4000, 10'h001);
      wait_cnt(1, b + 1, 3000, "tmo_sat");
      chk("sat_v",   pv[b], 32'hFFFF);
      chk("sat_t",   pt[b], 32'h0);
      chk("sat_flag", ps[b], 32'h1);
      pulse_abort();
      chk("sat_abort_busy", busy_o, 32'h0);
      chk("sat_abort_hold", d_code_o, 32'h1);

      // Majority vote: 1,0,1 -> up; then 0,0,1 -> flip.
      stb_auto_en = 1'b0;
      cyc(10);
      man_mode = 1'b1;
      w = wre_cnt;
      start_run(16'h0010, 10'h001);
      wait_cnt(0, w + 1, 50, "tmo_v_wre1");
      cyc(5);
      strobe(1'b1); strobe(1'b0); strobe(1'b1);
      wait_cnt(0, w + 2, 100, "tmo_v_wre2");
      chk("vote101_up", threshold_o, 32'h8010);
      cyc(5);
      b = pt_cnt;
      strobe(1'b0); strobe(1'b0); strobe(1'b1);
      wait_cnt(1, b + 1, 100, "tmo_v_pt");
      chk("vote001_v",   pv[b], 32'h8010);
      chk("vote001_t",   pt[b], 32'h0);
      chk("vote001_sat", ps[b], 32'h0);
      pulse_abort();
      man_mode = 1'b0;

      // DAC not ready after wre: no further writes or votes.
      stb_auto_en = 1'b1;
      level = 17'h08010;
      w = wre_cnt;
      start_run(16'h0008, 10'h100);
      wait_cnt(0, w + 1, 50, "tmo_rdy_wre1");
      threshold_rdy_i = 1'b0;
      b = pt_cnt;
      cyc(50);
      chk("rdy_low_wre",  wre_cnt, 32'(w + 1));
      chk("rdy_low_pt",   pt_cnt, 32'(b));
      chk("rdy_low_busy", busy_o, 32'h1);
      chk("rdy_low_thr",  threshold_o, 32'h8000);
      threshold_rdy_i = 1'b1;
      wait_cnt(0, w + 2, 300, "tmo_rdy_wre2");
      chk("rdy_back_step", threshold_o, 32'h8008);

      // Abort mid-vote on the second delay code, then restart.
      wait_cnt(1, b + 1, 3000, "tmo_ab_pt");
      chk("ab_pt_v", pv[b], 32'h8010);
      w = wre_cnt;
      wait_cnt(0, w + 1, 100, "tmo_ab_wre");
      cyc(6);
      d = done_cnt;
      b = pt_cnt;
      pulse_abort();
      chk("abort_busy", busy_o, 32'h0);
      chk("abort_hold_t", d_code_o, 32'h100);
      cyc(20);
      chk("abort_no_done", done_cnt, 32'(d));
      chk("abort_no_pt",   pt_cnt, 32'(b));
      run_i = 1'b1; abort_i = 1'b1;
      cyc(1);
      run_i = 1'b0; abort_i = 1'b0;
      chk("run_abort_idle", busy_o, 32'h0);
      start_run(16'h0008, 10'h100);
      chk("restart_busy", busy_o, 32'h1);
      chk("restart_t",    d_code_o, 32'h0);
      chk("restart_v",    threshold_o, 32'h8000);
      wait_cnt(1, b + 1, 3000, "tmo_restart_pt");
      chk("restart_pt_v", pv[b], 32'h8010);
      chk("restart_pt_t", pt[b], 32'h0);
      pulse_abort();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
